frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer.sv | 98 +++++++++
 tb/tb_frame_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: scans H_RES x V_RES pixels through a 2-stage sprite/ROM pipeline into a frame buffer
module frame_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter logic [3:0] TRANSP_IDX = 4'h0,
    parameter logic [3:0] BG_IDX = 4'h1
) (
    input  logic        Clk50,
    input  logic        Reset,
    input  logic        frame_start,
    output logic [9:0]  WriteX,
    output logic [9:0]  WriteY,
    input  logic        sprite_on_wr,
    input  logic [17:0] sprite_addr,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [3:0]  fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    localparam logic [9:0]  XL = 10'(H_RES - 1);
    localparam logic [9:0]  YL = 10'(V_RES - 1);
    localparam logic [18:0] AL = 19'(H_RES * V_RES - 1);
    localparam logic [18:0] HR = 19'(H_RES);
    state_t state_q, state_d;
    logic [9:0]  x_q, y_q;
    logic        v1_q, on1_q, v2_q, on2_q, hold_q, overrun_q;
    logic [17:0] ra_q;
    logic [18:0] a1_q, a2_q;
    logic [3:0]  pix_q, src;
    logic        adv, scan_go, last_px, acc_last;
    assign adv      = !(v2_q && !fb_ready);
    assign scan_go  = state_q == SCAN && adv;
    assign last_px  = x_q == XL && y_q == YL;
    assign acc_last = state_q == DRAIN && v2_q && fb_ready && a2_q == AL;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = frame_start ? SCAN : IDLE;
            SCAN:    state_d = (scan_go && last_px) ? DRAIN : SCAN;
            DRAIN:   state_d = acc_last ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk50) begin
        if (Reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            v1_q      <= 1'b0;
            on1_q     <= 1'b0;
            ra_q      <= '0;
            a1_q      <= '0;
            v2_q      <= 1'b0;
            on2_q     <= 1'b0;
            a2_q      <= '0;
            hold_q    <= 1'b0;
            pix_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_q | (frame_start && state_q != IDLE);
            if (scan_go) begin
                x_q <= (x_q == XL) ? '0 : x_q + 10'd1;
                y_q <= (x_q == XL) ? ((y_q == YL) ? '0 : y_q + 10'd1) : y_q;
            end
            if (adv) begin
                v1_q   <= state_q == SCAN;
                on1_q  <= sprite_on_wr;
                ra_q   <= sprite_addr;
                a1_q   <= 19'(y_q) * HR + 19'(x_q);
                v2_q   <= v1_q;
                on2_q  <= on1_q;
                a2_q   <= a1_q;
                hold_q <= 1'b0;
            end else if (!hold_q) begin
                // rom_addr now belongs to stage 1, so keep stage 2's ROM word for the rest of the stall
                hold_q <= 1'b1;
                pix_q  <= rom_data;
            end
        end
    end
    assign src      = hold_q ? pix_q : rom_data;
    assign WriteX   = x_q;
    assign WriteY   = y_q;
    assign rom_addr = ra_q;
    assign fb_we    = v2_q;
    assign fb_addr  = a2_q;
    assign fb_data  = v2_q ? ((on2_q && src != TRANSP_IDX) ? src : BG_IDX) : 4'h0;
    assign busy     = state_q != IDLE;
    assign done     = acc_last;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: randomized self-checking bench for frame_writer against a per-pixel reference model
module tb_frame_writer;
    localparam int H = 20, V = 12, N = H * V, X0 = 4, X1 = 9, Y0 = 3, Y1 = 6, SW = X1 - X0 + 1;
    localparam int LIMIT = 4 * N + 50;
    logic Clk50 = 0, Reset = 1, frame_start = 0, fb_ready = 1;
    logic [9:0] WriteX, WriteY;
    logic sprite_on_wr;
    logic [17:0] sprite_addr, rom_addr;
    logic [3:0] rom_data = 0, fb_data;
    logic fb_we, busy, done, overrun;
    logic [18:0] fb_addr;
    int total = 0, bad = 0, idx = 0, frames = 0, busy_n = 0, n10 = 0;
    bit en = 0, done_seen = 0, exp_over = 0, prev_st = 0, aborted;
    logic [18:0] prev_a;
    logic [9:0] prev_x;
    logic [3:0] got [N];

    frame_writer #(.H_RES(H), .V_RES(V), .TRANSP_IDX(4'h0), .BG_IDX(4'h1)) dut (
        .Clk50(Clk50), .Reset(Reset), .frame_start(frame_start), .WriteX(WriteX), .WriteY(WriteY),
        .sprite_on_wr(sprite_on_wr), .sprite_addr(sprite_addr), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .done(done), .overrun(overrun));

    always #5 Clk50 = ~Clk50;

    function automatic logic [3:0] rom_fn(input logic [17:0] a);
        return 4'(a * 7);
    endfunction

    function automatic bit in_spr(input int x, input int y);
        return x >= X0 && x <= X1 && y >= Y0 && y <= Y1;
    endfunction

    function automatic logic [17:0] saddr(input int x, input int y);
        return 18'((y - Y0) * SW + (x - X0));
    endfunction

    function automatic logic [3:0] exp_px(input int k);
        int x, y;
        x = k % H;
        y = k / H;
        if (in_spr(x, y) && rom_fn(saddr(x, y)) != 4'h0) return rom_fn(saddr(x, y));
        return 4'h1;
    endfunction

    assign sprite_on_wr = in_spr(int'(WriteX), int'(WriteY));
    assign sprite_addr  = sprite_on_wr ? saddr(int'(WriteX), int'(WriteY)) : 18'h0;
    always @(posedge Clk50) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, g, e, $time);
        end
    endtask

    task automatic step;
        @(posedge Clk50);
        #1;
    endtask

    always @(negedge Clk50) begin
        if (Reset) begin
            idx = 0;
            prev_st = 0;
        end else if (en) begin
            bit acc;
            acc = fb_we && fb_ready;
            chk("done", 32'(done), 32'(acc && idx == N - 1));
            chk("overrun", 32'(overrun), 32'(exp_over));
            if (prev_st) begin
                chk("hold_we", 32'(fb_we), 1);
                chk("hold_addr", 32'(fb_addr), 32'(prev_a));
                chk("hold_x", 32'(WriteX), 32'(prev_x));
            end
            if (acc) begin
                chk("addr", 32'(fb_addr), 32'(idx));
                chk("data", 32'(fb_data), 32'(exp_px(idx)));
                got[idx] = fb_data;
                if (idx == N - 1) begin
                    idx = 0;
                    done_seen = 1;
                    frames++;
                end else idx++;
            end
            if (busy) busy_n++;
            if (fb_we && fb_addr == 19'd10) n10++;
            prev_st = fb_we && !fb_ready;
            prev_a = fb_addr;
            prev_x = WriteX;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(WriteX), 0);
        chk({tag, "_y"}, 32'(WriteY), 0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_we"}, 32'(fb_we), 0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
        chk({tag, "_fb_data"}, 32'(fb_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    task automatic run_frame(input int mode, input int dup_at, input int abort_at, output bit ab);
        int cyc, st;
        cyc = 0;
        st = 0;
        ab = 0;
        done_seen = 0;
        frame_start = 1;
        step;
        frame_start = 0;
        while (!done_seen && cyc < LIMIT) begin
            if (abort_at >= 0 && idx >= abort_at) begin
                Reset = 1;
                step;
                chk_reset_vals("abort");
                Reset = 0;
                exp_over = 0;
                step;
                chk("post_reset_we", 32'(fb_we), 0);
                ab = 1;
                return;
            end
            if (mode == 0) fb_ready = 1;
            else if (mode == 1) fb_ready = 1'($urandom_range(0, 1));
            else if (fb_we && fb_addr == 19'd10 && st < 3) begin
                fb_ready = 0;
                st++;
            end else fb_ready = 1;
            if (cyc == dup_at) frame_start = 1;
            step;
            cyc++;
            if (frame_start) begin
                frame_start = 0;
                exp_over = 1;
            end
        end
        if (!done_seen) begin
            bad++;
            total++;
            $display("FAIL timeout: no done within %0d cycles", LIMIT);
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_x", 32'(WriteX), 0);
        chk("idle_y", 32'(WriteY), 0);
        chk("idle_we", 32'(fb_we), 0);
    endtask

    initial begin
        repeat (2) step;
        chk_reset_vals("reset");
        Reset = 0;
        en = 1;
        step;
        busy_n = 0;
        run_frame(0, -1, -1, aborted);
        chk("busy_cycles", 32'(busy_n), 32'(N + 2));
        chk("lit_addr0", 32'(got[0]), 1);
        chk("lit_corner_transp", 32'(got[Y0 * H + X0]), 1);
        chk("lit_spr_1", 32'(got[Y0 * H + X0 + 1]), 7);
        chk("lit_spr_2", 32'(got[Y0 * H + X0 + 2]), 14);
        chk("lit_spr_row2", 32'(got[(Y0 + 1) * H + X0]), 10);
        chk("lit_last", 32'(got[N - 1]), 1);
        n10 = 0;
        run_frame(2, 30, -1, aborted);
        chk("stall10_cycles", 32'(n10), 4);
        chk("overrun_set", 32'(overrun), 1);
        run_frame(1, -1, -1, aborted);
        chk("overrun_sticky", 32'(overrun), 1);
        run_frame(1, -1, 50, aborted);
        chk("aborted", 32'(aborted), 1);
        run_frame(1, -1, -1, aborted);
        chk("overrun_cleared", 32'(overrun), 0);
        chk("frames", 32'(frames), 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
